// File: rtl/spi_slave_param_pkg.sv
// spi_slave_param shared definitions:
// SPI mode encodings and the core FSM states.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    function automatic logic [1:0] mode_of(input int cpol, input int cpha);
        return {cpol != 0, cpha != 0};
    endfunction

    // sck level seen right after a sample edge
    function automatic logic sample_level(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Register-side bus of the SPI slave:
// TX holding handshake, RX word strobe and status pulses.
interface spi_slave_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             tx_underrun;
    logic             frame_abort;
    logic             busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid,
        input  tx_underrun, frame_abort, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid,
        output tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_param_sync_edge.sv
// Multi-flop synchroniser for an async pin with
// rise/fall pulses from last stage vs one extra copy.
module spi_sync_edge #(
    parameter int STAGES = 2,
    parameter bit INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              last_q, last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        last_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{INIT}};
            last_q <= INIT;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~last_q;
    assign fall = ~q & last_q;
endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: any CPOL/CPHA, WIDTH-bit words,
// back-to-back words per select, TX holding register.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck,
    input  logic                mosi,
    input  logic                enable,
    output logic                miso,
    spi_slave_param_if.slave    bus
);
    localparam int         CW         = $clog2(WIDTH);
    localparam logic       SAMPLE_LVL = sample_level(mode_of(CPOL, CPHA));
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic en_lvl, en_rise, en_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic mosi_s, sample_edge, shift_edge, start, wrap;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d, rx_next;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             skip_q, skip_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;
    logic             abort_q, abort_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(CPOL != 0)) u_sck (
        .clk(clk), .rst_n(rst_n), .d(sck),
        .q(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_en (
        .clk(clk), .rst_n(rst_n), .d(enable),
        .q(en_lvl), .rise(en_rise), .fall(en_fall)
    );

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_edge = (sck_rise | sck_fall) & (sck_lvl == SAMPLE_LVL);
    assign shift_edge  = (sck_rise | sck_fall) & (sck_lvl != SAMPLE_LVL);

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        skip_d      = skip_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        start       = 1'b0;
        wrap        = 1'b0;
        rx_next     = (LSB_FIRST != 0) ? {mosi_s, rx_sh_q[WIDTH-1:1]}
                                       : {rx_sh_q[WIDTH-2:0], mosi_s};
        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (en_fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    skip_d  = 1'b0;
                    abort_d = (cnt_q != '0);
                end else begin
                    if (shift_edge) begin
                        if (skip_q) skip_d = 1'b0;
                        else if (LSB_FIRST != 0) tx_sh_d = tx_sh_q >> 1;
                        else tx_sh_d = tx_sh_q << 1;
                    end
                    if (sample_edge) begin
                        rx_sh_d = rx_next;
                        if (cnt_q == LAST) begin
                            cnt_d      = '0;
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            start      = 1'b1;
                            wrap       = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
        endcase
        // A wrap in CPHA=0 lands before the last bit's trailing edge, which must not shift
        if (start) begin
            skip_d = (CPHA != 0) || wrap;
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d    = '0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            skip_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            skip_q      <= skip_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign miso = (state_q == ACTIVE) &
                  ((LSB_FIRST != 0) ? tx_sh_q[0] : tx_sh_q[WIDTH-1]);

    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = en_lvl;
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: four 32-bit LSB-first
// slaves (modes 0..3) and one 8-bit MSB-first mode-3 slave.
module tb_spi_slave_param;
    localparam int T = 35;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck_base = 1'b0;
    logic en_base = 1'b0;
    logic mosi_pin = 1'b0;
    int   sel = 0;

    logic [63:0] txd [5];
    logic        txv [5];
    wire  [63:0] rxd_w [5];
    wire         miso_w [5];
    wire         rdy_w [5];
    wire         rxv_w [5];
    wire         und_w [5];
    wire         abt_w [5];
    wire         busy_w [5];
    wire         sck_w [5];
    wire         en_w [5];

    int checks = 0;
    int failures = 0;
    int rx_cnt [5] = '{default: 0};
    int und_cnt [5] = '{default: 0};
    int abt_cnt [5] = '{default: 0};
    logic [63:0] rx_last [5] = '{default: 64'h0};
    logic [63:0] rx_prev [5] = '{default: 64'h0};

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_w32
        spi_slave_param_if #(.WIDTH(32)) bus ();
        assign sck_w[m]     = sck_base ^ (m >= 2);
        assign en_w[m]      = en_base && (sel == m);
        assign bus.tx_data  = txd[m][31:0];
        assign bus.tx_valid = txv[m];
        assign rxd_w[m]     = {32'h0, bus.rx_data};
        assign rdy_w[m]     = bus.tx_ready;
        assign rxv_w[m]     = bus.rx_valid;
        assign und_w[m]     = bus.tx_underrun;
        assign abt_w[m]     = bus.frame_abort;
        assign busy_w[m]    = bus.busy;
        spi_slave_param #(
            .WIDTH(32), .CPOL(m / 2), .CPHA(m % 2),
            .LSB_FIRST(1), .SYNC_STAGES(2)
        ) dut (
            .clk(clk), .rst_n(rst_n), .sck(sck_w[m]),
            .mosi(mosi_pin), .enable(en_w[m]),
            .miso(miso_w[m]), .bus(bus.slave)
        );
    end

    spi_slave_param_if #(.WIDTH(8)) bus8 ();
    assign sck_w[4]      = ~sck_base;
    assign en_w[4]       = en_base && (sel == 4);
    assign bus8.tx_data  = txd[4][7:0];
    assign bus8.tx_valid = txv[4];
    assign rxd_w[4]      = {56'h0, bus8.rx_data};
    assign rdy_w[4]      = bus8.tx_ready;
    assign rxv_w[4]      = bus8.rx_valid;
    assign und_w[4]      = bus8.tx_underrun;
    assign abt_w[4]      = bus8.frame_abort;
    assign busy_w[4]     = bus8.busy;

    spi_slave_param #(
        .WIDTH(8), .CPOL(1), .CPHA(1),
        .LSB_FIRST(0), .SYNC_STAGES(2)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .sck(sck_w[4]),
        .mosi(mosi_pin), .enable(en_w[4]),
        .miso(miso_w[4]), .bus(bus8.slave)
    );

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (rxv_w[k]) begin
                rx_cnt[k]++;
                rx_prev[k] = rx_last[k];
                rx_last[k] = rxd_w[k];
            end
            if (und_w[k]) und_cnt[k]++;
            if (abt_w[k]) abt_cnt[k]++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic load_tx(input int k, input logic [63:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_w[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ld_rdy", 128'(rdy_w[k]), 128'h1);
        txd[k] = w;
        txv[k] = 1'b1;
        @(negedge clk);
        txv[k] = 1'b0;
    endtask

    // stream bit i is the i-th bit on the wire
    task automatic spi_frame(input int k, input int nbits, input logic [127:0] mo,
                             output logic [127:0] mi, input bit close);
        bit cpha;
        cpha = (k == 4) ? 1'b1 : (k % 2 != 0);
        mi = '0;
        @(negedge clk);
        #2;
        sel = k;
        sck_base = 1'b0;
        mosi_pin = mo[0];
        #(T) en_base = 1'b1;
        #(T);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mi[i] = miso_w[k];
                sck_base = 1'b1;
                #(T);
                sck_base = 1'b0;
                if (i < 127) mosi_pin = mo[i+1];
                #(T);
            end else begin
                sck_base = 1'b1;
                mosi_pin = mo[i];
                #(T);
                mi[i] = miso_w[k];
                sck_base = 1'b0;
                #(T);
            end
        end
        if (close) begin
            #(T) en_base = 1'b0;
            #(2 * T);
        end
    endtask

    logic [127:0] mi;
    logic [31:0] pats [4] = '{32'h0F1E2D3C, 32'h80000001, 32'hFFFF0000, 32'h7E5A3C18};
    int r0, u0, a0;

    initial begin
        for (int k = 0; k < 5; k++) begin
            txd[k] = '0;
            txv[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_miso", 128'(miso_w[0]), 128'h0);
        chk("rst_rdy", 128'(rdy_w[0]), 128'h1);
        chk("rst_rxd", 128'(rxd_w[0]), 128'h0);
        chk("rst_busy", 128'(busy_w[0]), 128'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // mode 0 receive, nothing queued to send
        r0 = rx_cnt[0]; u0 = und_cnt[0];
        spi_frame(0, 32, {96'h0, 32'h55128602}, mi, 1'b1);
        chk("t1_rxcnt", 128'(rx_cnt[0] - r0), 128'd1);
        chk("t1_rxd", 128'(rx_last[0]), 128'h55128602);
        chk("t1_miso0", mi[31:0], 128'h0);
        chk("t1_und", 128'(und_cnt[0] - u0), 128'd2);

        for (int m = 0; m < 4; m++) begin
            r0 = rx_cnt[m]; u0 = und_cnt[m];
            load_tx(m, 64'hA5A50F0F);
            spi_frame(m, 32, {96'h0, pats[m]}, mi, 1'b1);
            chk($sformatf("t2_miso_m%0d", m), mi, 128'hA5A50F0F);
            chk($sformatf("t2_rxd_m%0d", m), 128'(rx_last[m]), 128'(pats[m]));
            chk($sformatf("t2_rxcnt_m%0d", m), 128'(rx_cnt[m] - r0), 128'd1);
            chk($sformatf("t2_und_m%0d", m), 128'(und_cnt[m] - u0), 128'd1);
        end

        // two words, both refills in time
        load_tx(0, 64'h13572468);
        r0 = rx_cnt[0]; u0 = und_cnt[0];
        fork
            spi_frame(0, 64, {64'h0, 32'hCAFEBABE, 32'h0BADF00D}, mi, 1'b1);
            begin
                #500 load_tx(0, 64'h9ABCDEF0);
                #2500 load_tx(0, 64'h0F0F1234);
            end
        join
        chk("t3_miso", mi, {64'h0, 32'h9ABCDEF0, 32'h13572468});
        chk("t3_rxcnt", 128'(rx_cnt[0] - r0), 128'd2);
        chk("t3_rxd1", 128'(rx_prev[0]), 128'h0BADF00D);
        chk("t3_rxd2", 128'(rx_last[0]), 128'hCAFEBABE);
        chk("t3_und", 128'(und_cnt[0] - u0), 128'd0);

        // second word not supplied
        load_tx(0, 64'h00C0FFEE);
        u0 = und_cnt[0];
        spi_frame(0, 64, {64'h0, 32'h11112222, 32'h33334444}, mi, 1'b1);
        chk("t3b_miso", mi, 128'h00C0FFEE);
        chk("t3b_und", 128'(und_cnt[0] - u0), 128'd2);

        // abort after 13 bits
        r0 = rx_cnt[0]; a0 = abt_cnt[0];
        spi_frame(0, 13, {96'h0, 32'hFFFFFFFF}, mi, 1'b1);
        chk("t4_abort", 128'(abt_cnt[0] - a0), 128'd1);
        chk("t4_norx", 128'(rx_cnt[0] - r0), 128'd0);
        a0 = abt_cnt[0];
        spi_frame(0, 32, {96'h0, 32'h00000001}, mi, 1'b1);
        chk("t4_rxd", 128'(rx_last[0]), 128'h1);
        chk("t4_rxcnt", 128'(rx_cnt[0] - r0), 128'd1);
        chk("t4_noabort", 128'(abt_cnt[0] - a0), 128'd0);

        // reset in the middle of a word with holding register full
        load_tx(0, 64'h11111111);
        spi_frame(0, 20, {96'h0, 32'hDEADBEEF}, mi, 1'b0);
        load_tx(0, 64'h22222222);
        chk("t5_full", 128'(rdy_w[0]), 128'h0);
        r0 = rx_cnt[0]; a0 = abt_cnt[0];
        @(negedge clk);
        rst_n = 1'b0;
        en_base = 1'b0;
        @(negedge clk);
        chk("t5_rdy", 128'(rdy_w[0]), 128'h1);
        chk("t5_rxd", 128'(rxd_w[0]), 128'h0);
        chk("t5_miso", 128'(miso_w[0]), 128'h0);
        chk("t5_busy", 128'(busy_w[0]), 128'h0);
        chk("t5_rxv", 128'(rxv_w[0]), 128'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_nopulse", 128'((rx_cnt[0] - r0) + (abt_cnt[0] - a0)), 128'd0);
        load_tx(0, 64'h600DC0DE);
        spi_frame(0, 32, {96'h0, 32'h2468ACE1}, mi, 1'b1);
        chk("t5_miso_after", mi, 128'h600DC0DE);
        chk("t5_rxd_after", 128'(rx_last[0]), 128'h2468ACE1);

        // 8-bit, MSB first, mode 3, two words
        load_tx(4, 64'h3C);
        r0 = rx_cnt[4];
        fork
            spi_frame(4, 16, {112'h0, rev8(8'hA1), rev8(8'hC3)}, mi, 1'b1);
            #200 load_tx(4, 64'h96);
        join
        chk("t6_miso", mi, {112'h0, rev8(8'h96), rev8(8'h3C)});
        chk("t6_rxcnt", 128'(rx_cnt[4] - r0), 128'd2);
        chk("t6_rxd1", 128'(rx_prev[4]), 128'hC3);
        chk("t6_rxd2", 128'(rx_last[4]), 128'hA1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
